// File: rtl/uart_pkg.sv
// Shared definitions for the UART command-frame decoder.
//   state_e      : decoder FSM states
//   ERR_*        : o_Err_Code values
//   FRAME_LEN    : bytes per frame (SYNC, OP, ADDR, D0..D3, CHK)
//   sat_inc8     : 8-bit saturating increment used by the error counter
package uart_pkg;

  localparam int unsigned FRAME_LEN = 8;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_OP   = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_HOLD = 3'd5
  } state_e;

  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : restart the count (a byte arrived)
//   enable_i      : count only while a frame is in progress; held at 0 otherwise
//   expired_o     : combinational pulse on the clock whose edge would make the
//                   idle count reach TIMEOUT_CLKS
module uart_idle_timer #(
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count k after k idle edges; the edge that would make it TIMEOUT_CLKS is the expiry edge.
  assign expired_o = enable_i && !clear_i && (cnt_q == CNT_W'(TIMEOUT_CLKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i || expired_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes 8-byte command frames (SYNC, OP, ADDR, D0..D3, CHK) from a UART
// receiver byte stream. CHK is the XOR of OP..D3; data is little-endian.
//   i_Clock, i_Reset_n       : clock, asynchronous active-low reset
//   i_Rx_DV, i_Rx_Byte       : received byte and its one-cycle valid strobe
//   i_Cmd_Ready              : consumer accepts the held command
//   o_Cmd_Valid/Op/Addr/Data : decoded command, stable while held
//   o_Err, o_Err_Code        : one-cycle error pulse and sticky cause
//   o_Err_Count              : saturating error count
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Cmd_Ready,
  output logic        o_Cmd_Valid,
  output logic [7:0]  o_Cmd_Op,
  output logic [7:0]  o_Cmd_Addr,
  output logic [31:0] o_Cmd_Data,
  output logic        o_Err,
  output logic [1:0]  o_Err_Code,
  output logic [7:0]  o_Err_Count
);

  localparam int unsigned DATA_BYTES = FRAME_LEN - 4;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  xor_q, xor_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        in_frame;
  logic        timeout;

  assign in_frame = (state_q == S_OP) || (state_q == S_ADDR) ||
                    (state_q == S_DATA) || (state_q == S_CHK);

  uart_idle_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_idle_timer (
    .clk_i    (i_Clock),
    .rst_ni   (i_Reset_n),
    .clear_i  (i_Rx_DV),
    .enable_i (in_frame),
    .expired_o(timeout)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    xor_d      = xor_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      S_SYNC: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = S_OP;
          xor_d   = '0;
          idx_d   = '0;
        end
      end

      S_OP: begin
        if (i_Rx_DV) begin
          op_d    = i_Rx_Byte;
          xor_d   = xor_q ^ i_Rx_Byte;
          state_d = S_ADDR;
        end else if (timeout) begin
          state_d    = S_SYNC;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end

      S_ADDR: begin
        if (i_Rx_DV) begin
          addr_d  = i_Rx_Byte;
          xor_d   = xor_q ^ i_Rx_Byte;
          state_d = S_DATA;
        end else if (timeout) begin
          state_d    = S_SYNC;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end

      S_DATA: begin
        if (i_Rx_DV) begin
          data_d[{idx_q, 3'b000} +: 8] = i_Rx_Byte;
          xor_d = xor_q ^ i_Rx_Byte;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'(DATA_BYTES - 1)) begin
            state_d = S_CHK;
          end
        end else if (timeout) begin
          state_d    = S_SYNC;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end

      S_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == xor_q) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
          end else begin
            state_d    = S_SYNC;
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
        end else if (timeout) begin
          state_d    = S_SYNC;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end

      S_HOLD: begin
        if (i_Cmd_Ready) begin
          // A byte arriving on the transfer clock belongs to the next frame.
          valid_d = 1'b0;
          state_d = S_SYNC;
          if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
            state_d = S_OP;
            xor_d   = '0;
            idx_d   = '0;
          end
        end else if (i_Rx_DV) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
      end

      default: begin
        state_d = S_SYNC;
        valid_d = 1'b0;
      end
    endcase

    if (err_d) begin
      err_cnt_d = sat_inc8(err_cnt_q);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= S_SYNC;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      xor_q      <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      xor_q      <= xor_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_Cmd_Valid = valid_q;
  assign o_Cmd_Op    = op_q;
  assign o_Cmd_Addr  = addr_q;
  assign o_Cmd_Data  = data_q;
  assign o_Err       = err_q;
  assign o_Err_Code  = err_code_q;
  assign o_Err_Count = err_cnt_q;

endmodule
